// File: rtl/mcsr_trap_ctrl_pkg.sv
// Shared constants for the machine-mode CSR / trap controller.
package mcsr_pkg;

    // CSR address map
    localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
    localparam logic [11:0] ADDR_MISA          = 12'h301;
    localparam logic [11:0] ADDR_MIE           = 12'h304;
    localparam logic [11:0] ADDR_MTVEC         = 12'h305;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
    localparam logic [11:0] ADDR_MEPC          = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE        = 12'h342;
    localparam logic [11:0] ADDR_MTVAL         = 12'h343;
    localparam logic [11:0] ADDR_MIP           = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;
    localparam logic [11:0] ADDR_MVENDORID     = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID       = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID        = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID       = 12'hF14;

    typedef enum logic [1:0] {
        CSR_READ = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    // mstatus field positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // mip / mie interrupt bit positions
    localparam int IRQ_MSI_BIT = 3;
    localparam int IRQ_MTI_BIT = 7;
    localparam int IRQ_MEI_BIT = 11;
    localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

    // interrupt cause codes
    localparam logic [30:0] CAUSE_MSI = 31'd3;
    localparam logic [30:0] CAUSE_MTI = 31'd7;
    localparam logic [30:0] CAUSE_MEI = 31'd11;

endpackage

// File: rtl/mcsr_trap_ctrl_if.sv
// CSR access bus between the core (master) and the CSR file (slave).
interface mcsr_trap_ctrl_if;
    logic [1:0]  csr_op;
    logic        csr_valid;
    logic [11:0] csr_address;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_op, csr_valid, csr_address, csr_wdata,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_op, csr_valid, csr_address, csr_wdata,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/mcsr_trap_ctrl_counter.sv
// Wide performance counter with inhibit and half-word CSR overwrite.
module mcsr_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 inhibit,
    input  logic                 wr_lo,
    input  logic                 wr_hi,
    input  logic [31:0]          wdata,
    output logic [CNT_WIDTH-1:0] value
);

    // A CSR write to either half wins over (and suppresses) the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (wr_lo) begin
            value[31:0] <= wdata;
        end else if (wr_hi) begin
            value[CNT_WIDTH-1:32] <= wdata[CNT_WIDTH-33:0];
        end else if (inc && !inhibit) begin
            value <= value + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/mcsr_trap_ctrl.sv
// Machine-mode CSR file: CSR ops, counters, interrupt logic, trap/mret.
module mcsr_trap_ctrl
    import mcsr_pkg::*;
#(
    parameter int          CNT_WIDTH   = 64,
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [25:0] MISA_EXT    = 26'h100,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mcsr_trap_ctrl_if.slave      csr_bus,
    input  logic                 trap_valid,
    input  logic                 trap_is_irq,
    input  logic [30:0]          trap_cause,
    input  logic [31:0]          trap_pc,
    input  logic [31:0]          trap_tval,
    output logic [31:0]          trap_target,
    input  logic                 mret,
    output logic [31:0]          mret_target,
    input  logic                 instret_inc,
    input  logic                 irq_msip,
    input  logic                 irq_mtip,
    input  logic                 irq_meip,
    output logic                 irq_pending,
    output logic [30:0]          irq_cause,
    output logic                 mstatus_mie
);

    localparam logic [31:0] MISA_VAL = {2'b01, 4'b0000, MISA_EXT};

    csr_op_e        op;
    logic           mie_flag, mpie_flag;
    logic [29:0]    mtvec_base;
    logic [1:0]     mtvec_mode;
    logic [31:0]    mscratch, mepc, mcause, mtval, mie_reg, mip_reg;
    logic           inhibit_cy, inhibit_ir;
    logic [CNT_WIDTH-1:0] cycle_cnt, instret_cnt;
    logic [63:0]    cycle_ext, instret_ext;
    logic [31:0]    rdata, wval, mstatus_val, mip_next, pend;
    logic           mapped, read_only, illegal, do_write;

    assign op          = csr_op_e'(csr_bus.csr_op);
    assign cycle_ext   = 64'(cycle_cnt);
    assign instret_ext = 64'(instret_cnt);

    // mstatus view and registered interrupt line sampling
    always_comb begin
        mstatus_val                   = '0;
        mstatus_val[12:11]            = 2'b11;
        mstatus_val[MSTATUS_MPIE_BIT] = mpie_flag;
        mstatus_val[MSTATUS_MIE_BIT]  = mie_flag;
        mip_next                      = '0;
        mip_next[IRQ_MSI_BIT]         = irq_msip;
        mip_next[IRQ_MTI_BIT]         = irq_mtip;
        mip_next[IRQ_MEI_BIT]         = irq_meip;
    end

    // Combinational read mux; also classifies the address as mapped / read-only
    always_comb begin
        rdata     = '0;
        mapped    = 1'b1;
        read_only = 1'b0;
        case (csr_bus.csr_address)
            ADDR_MSTATUS:       rdata = mstatus_val;
            ADDR_MISA:          begin rdata = MISA_VAL; read_only = 1'b1; end
            ADDR_MIE:           rdata = mie_reg;
            ADDR_MTVEC:         rdata = {mtvec_base, mtvec_mode};
            ADDR_MCOUNTINHIBIT: rdata = {29'b0, inhibit_ir, 1'b0, inhibit_cy};
            ADDR_MSCRATCH:      rdata = mscratch;
            ADDR_MEPC:          rdata = mepc;
            ADDR_MCAUSE:        rdata = mcause;
            ADDR_MTVAL:         rdata = mtval;
            ADDR_MIP:           begin rdata = mip_reg; read_only = 1'b1; end
            ADDR_MCYCLE:        rdata = cycle_ext[31:0];
            ADDR_MCYCLEH:       rdata = cycle_ext[63:32];
            ADDR_MINSTRET:      rdata = instret_ext[31:0];
            ADDR_MINSTRETH:     rdata = instret_ext[63:32];
            ADDR_CYCLE:         begin rdata = cycle_ext[31:0];    read_only = 1'b1; end
            ADDR_CYCLEH:        begin rdata = cycle_ext[63:32];   read_only = 1'b1; end
            ADDR_INSTRET:       begin rdata = instret_ext[31:0];  read_only = 1'b1; end
            ADDR_INSTRETH:      begin rdata = instret_ext[63:32]; read_only = 1'b1; end
            ADDR_MVENDORID,
            ADDR_MARCHID,
            ADDR_MIMPID:        read_only = 1'b1;
            ADDR_MHARTID:       begin rdata = HART_ID; read_only = 1'b1; end
            default:            mapped = 1'b0;
        endcase
    end

    // Write value for the current op; trap and mret take precedence over CSR writes
    always_comb begin
        case (op)
            CSR_RW:  wval = csr_bus.csr_wdata;
            CSR_RS:  wval = rdata | csr_bus.csr_wdata;
            CSR_RC:  wval = rdata & ~csr_bus.csr_wdata;
            default: wval = rdata;
        endcase
        illegal  = csr_bus.csr_valid & (~mapped | ((op != CSR_READ) & read_only));
        do_write = csr_bus.csr_valid & (op != CSR_READ) & ~illegal & ~trap_valid & ~mret;
    end

    assign csr_bus.csr_rdata   = rdata;
    assign csr_bus.csr_illegal = illegal;

    // Architectural state: trap entry, then mret, then CSR writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_flag   <= 1'b0;
            mpie_flag  <= 1'b0;
            mtvec_base <= '0;
            mtvec_mode <= '0;
            mscratch   <= '0;
            mepc       <= '0;
            mcause     <= '0;
            mtval      <= '0;
            mie_reg    <= '0;
            mip_reg    <= '0;
            inhibit_cy <= 1'b0;
            inhibit_ir <= 1'b0;
        end else begin
            mip_reg <= mip_next;
            if (trap_valid) begin
                mepc      <= {trap_pc[31:2], 2'b00};
                mcause    <= {trap_is_irq, trap_cause};
                mtval     <= trap_tval;
                mpie_flag <= mie_flag;
                mie_flag  <= 1'b0;
            end else if (mret) begin
                mie_flag  <= mpie_flag;
                mpie_flag <= 1'b1;
            end else if (do_write) begin
                case (csr_bus.csr_address)
                    ADDR_MSTATUS: begin
                        mie_flag  <= wval[MSTATUS_MIE_BIT];
                        mpie_flag <= wval[MSTATUS_MPIE_BIT];
                    end
                    ADDR_MIE:   mie_reg <= wval & IRQ_MASK;
                    ADDR_MTVEC: begin
                        mtvec_base <= wval[31:2];
                        if (wval[1:0] == 2'd0)
                            mtvec_mode <= 2'd0;
                        else if (wval[1:0] == 2'd1 && VECTORED_EN)
                            mtvec_mode <= 2'd1;
                    end
                    ADDR_MCOUNTINHIBIT: begin
                        inhibit_cy <= wval[0];
                        inhibit_ir <= wval[2];
                    end
                    ADDR_MSCRATCH: mscratch <= wval;
                    ADDR_MEPC:     mepc     <= {wval[31:2], 2'b00};
                    ADDR_MCAUSE:   mcause   <= wval;
                    ADDR_MTVAL:    mtval    <= wval;
                    default: ;
                endcase
            end
        end
    end

    mcsr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (1'b1),
        .inhibit (inhibit_cy),
        .wr_lo   (do_write && csr_bus.csr_address == ADDR_MCYCLE),
        .wr_hi   (do_write && csr_bus.csr_address == ADDR_MCYCLEH),
        .wdata   (wval),
        .value   (cycle_cnt)
    );

    mcsr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (instret_inc),
        .inhibit (inhibit_ir),
        .wr_lo   (do_write && csr_bus.csr_address == ADDR_MINSTRET),
        .wr_hi   (do_write && csr_bus.csr_address == ADDR_MINSTRETH),
        .wdata   (wval),
        .value   (instret_cnt)
    );

    // Interrupt arbitration (11 > 3 > 7) and redirect targets
    always_comb begin
        pend        = mip_reg & mie_reg;
        irq_pending = mie_flag & (|pend);
        if (pend[IRQ_MEI_BIT])      irq_cause = CAUSE_MEI;
        else if (pend[IRQ_MSI_BIT]) irq_cause = CAUSE_MSI;
        else if (pend[IRQ_MTI_BIT]) irq_cause = CAUSE_MTI;
        else                        irq_cause = '0;
        trap_target = {mtvec_base, 2'b00};
        if (mtvec_mode == 2'd1 && trap_is_irq)
            trap_target = {mtvec_base, 2'b00} + {trap_cause[29:0], 2'b00};
    end

    assign mret_target = mepc;
    assign mstatus_mie = mie_flag;

endmodule
